// File: rtl/axis_stream_bfm.sv
// rtl/axis_stream_bfm.sv - AXI4-Stream transmit/receive bus-functional block with task-level beat access
module axis_stream_bfm #(
   parameter int TDATA_BYTES = 1,
   parameter int RX_DEPTH    = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   output logic [8*TDATA_BYTES-1:0] m_tdata,
   output logic                     m_tvalid,
   output logic                     m_tlast,
   input  logic                     m_tready,
   input  logic [8*TDATA_BYTES-1:0] s_tdata,
   input  logic                     s_tvalid,
   input  logic                     s_tlast,
   output logic                     s_tready
);

   localparam int W = 8 * TDATA_BYTES;

   typedef enum logic {
      TX_IDLE,
      TX_PRESENT
   } tx_state_t;

   tx_state_t tx_state;

   // Beats are stored as {tdata, tlast}. Storage is append-only and walked by
   // index so that each queue has a single writer: the put task appends to
   // tx_q while the clocked logic only advances tx_head; the clocked logic
   // appends to rx_q while the get task only advances rx_rd_cnt.
   logic [W:0] tx_q [$];
   int         tx_head;

   logic [W:0] rx_q [$];
   int         rx_wr_cnt;
   int         rx_rd_cnt;
   int         rx_ticket;

   // Beats captured but not yet handed to a get_simple_beat caller.
   function automatic int rx_occupancy();
      return rx_wr_cnt - rx_rd_cnt;
   endfunction

   // Append one beat to the transmit queue; returns in zero time.
   task automatic put_simple_beat(input logic [W-1:0] tdata, input logic tlast);
      tx_q.push_back({tdata, tlast});
   endtask

   // Block until the oldest unclaimed beat is available, then return it.
   // A ticket taken at call time keeps concurrent callers in call order.
   task automatic get_simple_beat(output logic [W-1:0] tdata, output logic tlast);
      int         ticket;
      logic [W:0] beat;
      ticket    = rx_ticket;
      rx_ticket = rx_ticket + 1;
      wait ((rx_rd_cnt == ticket) && (rx_wr_cnt > ticket));
      beat          = rx_q[ticket];
      {tdata, tlast} = beat;
      rx_rd_cnt     = rx_rd_cnt + 1;
   endtask

   // Transmit FSM: present the head beat, advance on handshake, no bubble between queued beats.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         // tx_head is left alone so an unaccepted beat is re-presented after release.
         tx_state <= TX_IDLE;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else if (tx_state == TX_IDLE) begin
         if (tx_head < tx_q.size()) begin
            tx_state            <= TX_PRESENT;
            m_tvalid            <= 1'b1;
            {m_tdata, m_tlast}  <= tx_q[tx_head];
         end
      end else begin
         if (m_tready) begin
            tx_head <= tx_head + 1;
            if (tx_head + 1 < tx_q.size()) begin
               {m_tdata, m_tlast} <= tx_q[tx_head + 1];
            end else begin
               tx_state <= TX_IDLE;
               m_tvalid <= 1'b0;
            end
         end
      end
   end

   // Receive side: capture on handshake and keep s_tready low while the queue is full.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         s_tready <= 1'b0;
      end else begin
         if (s_tvalid && s_tready) begin
            rx_q.push_back({s_tdata, s_tlast});
            rx_wr_cnt <= rx_wr_cnt + 1;
         end
         s_tready <= (rx_occupancy() + ((s_tvalid && s_tready) ? 1 : 0)) < RX_DEPTH;
      end
   end

endmodule

// File: tb/tb_axis_stream_bfm.sv
// tb/tb_axis_stream_bfm.sv - directed and randomized bench for axis_stream_bfm
module tb_axis_stream_bfm;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tlast;
   logic       m_tready;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tlast;
   logic       s_tready;

   logic       loop;
   logic       tx_ready;
   logic [7:0] drv_tdata;
   logic       drv_tvalid;
   logic       drv_tlast;

   int checks = 0;
   int errors = 0;

   // Reference model: beats as {tdata, tlast}, strict FIFO on each side.
   logic [8:0] tx_exp [$];
   logic [8:0] tx_obs [$];
   logic [8:0] rx_exp [$];

   logic       stall_seen = 1'b0;
   logic [8:0] stall_beat = '0;

   always #5 clk = ~clk;

   assign m_tready = loop ? s_tready : tx_ready;
   assign s_tdata  = loop ? m_tdata  : drv_tdata;
   assign s_tvalid = loop ? m_tvalid : drv_tvalid;
   assign s_tlast  = loop ? m_tlast  : drv_tlast;

   axis_stream_bfm #(.TDATA_BYTES(1), .RX_DEPTH(2)) dut (
      .aclk     (clk),
      .aresetn  (resetn),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tb_put(input logic [7:0] d, input logic l);
      dut.put_simple_beat(d, l);
      tx_exp.push_back({d, l});
   endtask

   task automatic wait_tx(input int n);
      int c = 0;
      while (tx_obs.size() < n && c < 300) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic check_tx(input string tag);
      logic [31:0] o;
      check({tag, "_count"}, 32'(tx_obs.size()), 32'(tx_exp.size()));
      for (int i = 0; i < tx_exp.size(); i++) begin
         o = (i < tx_obs.size()) ? 32'(tx_obs[i]) : 32'hDEAD_BEEF;
         check(tag, o, 32'(tx_exp[i]));
      end
      tx_obs.delete();
      tx_exp.delete();
   endtask

   task automatic rx_send(input logic [7:0] d, input logic l);
      int c = 0;
      drv_tdata  = d;
      drv_tlast  = l;
      drv_tvalid = 1'b1;
      while (!s_tready && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("rx_send_ready", 32'(s_tready), 32'd1);
      @(negedge clk);
      drv_tvalid = 1'b0;
      rx_exp.push_back({d, l});
   endtask

   task automatic tb_get(input string tag);
      logic [7:0]  d;
      logic        l;
      logic [31:0] e;
      int          c = 0;
      while (dut.rx_occupancy() == 0 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_avail"}, 32'(dut.rx_occupancy() > 0), 32'd1);
      if (dut.rx_occupancy() > 0) begin
         dut.get_simple_beat(d, l);
         e = 32'hDEAD_BEEF;
         if (rx_exp.size() > 0) e = 32'(rx_exp.pop_front());
         check(tag, 32'({d, l}), e);
      end
   endtask

   // Transfer monitor, sampled mid-cycle: records handshakes and checks hold under backpressure.
   always begin
      @(negedge clk);
      #1;
      if (stall_seen)
         check("tx_hold", 32'({m_tvalid, m_tdata, m_tlast}), 32'({1'b1, stall_beat}));
      stall_seen = resetn && m_tvalid && !m_tready;
      stall_beat = {m_tdata, m_tlast};
      if (resetn && m_tvalid && m_tready) tx_obs.push_back({m_tdata, m_tlast});
   end

   initial begin
      logic [7:0] d;
      logic       l;
      resetn     = 1'b0;
      loop       = 1'b0;
      tx_ready   = 1'b0;
      drv_tdata  = '0;
      drv_tvalid = 1'b0;
      drv_tlast  = 1'b0;

      // Reset hold with a beat queued at time 0.
      tb_put(8'h37, 1'b0);
      repeat (10) begin
         @(negedge clk);
         check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
         check("rst_s_tready", 32'(s_tready), 32'd0);
      end
      resetn = 1'b1;
      @(negedge clk);
      check("rel_m_tvalid", 32'(m_tvalid), 32'd1);
      check("rel_m_tdata", 32'(m_tdata), 32'h37);
      check("rel_m_tlast", 32'(m_tlast), 32'd0);
      check("rel_s_tready", 32'(s_tready), 32'd1);
      repeat (2) @(negedge clk);
      tx_ready = 1'b1;
      wait_tx(1);
      check_tx("reset_beat");

      // Burst with ready tied high: three consecutive beats, then idle.
      tb_put(8'h37, 1'b0);
      tb_put(8'h48, 1'b0);
      tb_put(8'h59, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("burst_valid", 32'(m_tvalid), 32'd1);
         check("burst_beat", 32'({m_tdata, m_tlast}), 32'(tx_exp[i]));
      end
      @(negedge clk);
      check("burst_idle", 32'(m_tvalid), 32'd0);
      check_tx("burst");

      // Backpressure: 5-cycle stall mid-burst plus random ready afterwards.
      tb_put(8'h37, 1'b0);
      tb_put(8'h48, 1'b0);
      tb_put(8'h59, 1'b1);
      repeat (5) begin
         d = 8'($urandom);
         l = 1'($urandom_range(0, 1));
         tb_put(d, l);
      end
      for (int c = 0; c < 300 && tx_obs.size() < tx_exp.size(); c++) begin
         @(negedge clk);
         tx_ready = (c >= 1 && c < 6) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      check("bp_idle", 32'(m_tvalid), 32'd0);
      check_tx("backpressure");

      // Receive and RX-full behaviour with depth 2.
      rx_send(8'hC8, 1'b0);
      rx_send(8'hB7, 1'b0);
      check("rx_full_ready", 32'(s_tready), 32'd0);
      drv_tdata  = 8'hA6;
      drv_tlast  = 1'b1;
      drv_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rx_full_hold", 32'(s_tready), 32'd0);
      end
      tb_get("rx_first");
      @(negedge clk);
      check("rx_ready_reassert", 32'(s_tready), 32'd1);
      @(negedge clk);
      drv_tvalid = 1'b0;
      rx_exp.push_back({8'hA6, 1'b1});
      tb_get("rx_second");
      tb_get("rx_third");

      // Loopback: fixed sequence then random beats, through a 2-deep receive queue.
      loop = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         d = 8'(i);
         l = (i == 8);
         tb_put(d, l);
         rx_exp.push_back({d, l});
      end
      repeat (10) begin
         d = 8'($urandom);
         l = 1'($urandom_range(0, 1));
         tb_put(d, l);
         rx_exp.push_back({d, l});
      end
      for (int i = 0; i < 18; i++) tb_get("loop_beat");
      wait_tx(18);
      check_tx("loopback");
      @(negedge clk);
      check("end_idle", 32'(m_tvalid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
